// File: rtl/lsh_pkg.sv
// Shared types and constants for the lsh shift sequencer.
// Holds the FSM state encoding and the overflow mask helper.
package lsh_pkg;

    localparam int DATA_W   = 7;
    localparam int STEP_MAX = 7;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Mask of the top k bits of a data word: the bits a k-bit left
    // shift pushes out past the MSB.
    function automatic logic [DATA_W-1:0] out_mask(input logic [2:0] k);
        return ~({DATA_W{1'b1}} >> k);
    endfunction

endpackage

// File: rtl/lsh.sv
// Combinational 7-bit left shifter, 0..7 positions per use.
// Bits moved past bit 6 are dropped.
module lsh
    import lsh_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [2:0]        f,
    output logic [DATA_W-1:0] y
);

    assign y = a << f;

endmodule

// File: rtl/lsh_seq.sv
// Multi-pass shift sequencer around lsh with valid/ready on both sides.
// Splits the shift amount into passes of at most STEP_MAX bits.
module lsh_seq
    import lsh_pkg::*;
#(
    parameter int AMT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ovf,
    output logic              busy
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_acc;
    logic [AMT_W-1:0]   r_rem;
    logic               r_ovf;

    logic [2:0]         w_k;
    logic [AMT_W-1:0]   w_rem_nxt;
    logic [DATA_W-1:0]  w_shifted;
    logic               w_ovf_term;
    logic               w_accept;

    assign w_k = (r_rem > AMT_W'(STEP_MAX)) ? 3'(STEP_MAX) : r_rem[2:0];
    assign w_rem_nxt = r_rem - AMT_W'(w_k);
    assign w_ovf_term = |(r_acc & out_mask(w_k));
    assign w_accept = in_valid & in_ready;

    lsh u_lsh (
        .a (r_acc),
        .f (w_k),
        .y (w_shifted)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        out_ovf     = 1'b0;
        busy        = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (w_rem_nxt == '0) w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                out_data  = r_acc;
                out_ovf   = r_ovf;
                in_ready  = out_ready;
                if (out_ready) w_state_nxt = in_valid ? SHIFT : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: load on accept, one lsh pass per SHIFT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
            r_rem <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_acc <= in_data;
            r_rem <= in_amt;
            r_ovf <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_acc <= w_shifted;
            r_rem <= w_rem_nxt;
            r_ovf <= r_ovf | w_ovf_term;
        end
    end

endmodule

// File: tb/tb_lsh_seq.sv
// Randomized self-checking bench for lsh_seq.
// Reference: plain wide shift of the operand by the full amount.
module tb_lsh_seq;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_data;
    logic [3:0] in_amt;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out_data;
    logic       out_ovf;
    logic       busy;

    int n_chk;
    int n_pass;

    logic [6:0] exp_d;
    logic       exp_o;
    int         exp_p;

    lsh_seq #(.AMT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive a command and compute its expected result from the full shift.
    task automatic launch(input logic [6:0] d, input logic [3:0] a);
        logic [31:0] wide;
        wide     = 32'(d) << a;
        exp_d    = wide[6:0];
        exp_o    = |wide[31:7];
        exp_p    = (a == 4'd0) ? 1 : (int'(a) + 6) / 7;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
    endtask

    // Called at the negedge after the accepting edge.
    task automatic collect();
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            chk("busy_shift", 32'(busy), 1);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_p);
        chk("out_data", 32'(out_data), 32'(exp_d));
        chk("out_ovf", 32'(out_ovf), 32'(exp_o));
        chk("busy_done", 32'(busy), 0);
    endtask

    task automatic hold_chk(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_data", 32'(out_data), 32'(exp_d));
            chk("hold_ovf", 32'(out_ovf), 32'(exp_o));
            chk("hold_in_ready", 32'(in_ready), 0);
        end
    endtask

    task automatic release_chk();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("in_ready_done", 32'(in_ready), 1);
        @(negedge clk);
        chk("idle_valid", 32'(out_valid), 0);
        chk("idle_in_ready", 32'(in_ready), 1);
        out_ready = 1'b0;
    endtask

    // Full transaction; junk on the inputs while busy must be ignored.
    task automatic run_op(input logic [6:0] d, input logic [3:0] a,
                          input int hold);
        launch(d, a);
        #1;
        chk("in_ready_idle", 32'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 7'($urandom);
        in_amt   = 4'($urandom);
        collect();
        hold_chk(hold);
        release_chk();
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_ovf", 32'(out_ovf), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        @(negedge clk);

        run_op(7'b0000011, 4'd2, 0);
        run_op(7'b0000001, 4'd9, 1);
        run_op(7'h55, 4'd0, 0);
        run_op(7'h7F, 4'd15, 2);
        run_op(7'h01, 4'd7, 0);
        run_op(7'h01, 4'd6, 0);

        // Backpressure then same-edge handshake on both sides.
        launch(7'h2A, 4'd4);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        collect();
        hold_chk(5);
        out_ready = 1'b1;
        launch(7'h01, 4'd3);
        #1;
        chk("b2b_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_no_bubble", 32'(busy), 1);
        collect();
        chk("b2b_result", 32'(out_data), 32'h08);
        release_chk();

        // Reset in the middle of a long operation.
        launch(7'h7F, 4'd15);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_quiet", 32'(out_valid), 0);
        end
        run_op(7'h13, 4'd5, 0);

        for (int i = 0; i < 60; i++) begin
            run_op(7'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Hard stop in case the bench itself stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
